// File: rtl/flash_page_writer.sv
// SPI NOR page-program sequencer: WREN, PAGE PROGRAM with streamed payload,
// then RDSR polling until WIP clears or the poll budget runs out.
module flash_page_writer #(
    parameter int CS_GAP_CYCLES = 4,
    parameter int POLL_MAX      = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] address,
    input  logic [8:0]  byte_count,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_cs,
    output logic [3:0]  dbg_state
);

    localparam int GW = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES) : 1;
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, CHECK, WREN, GAP1, PP_CMD, PP_ADDR, PP_DATA, GAP2, RDSR, POLL_GAP, FINISH
    } state_t;

    state_t        state, state_n;
    logic [23:0]   addr_q, addr_n;
    logic [8:0]    bytes_left, bytes_left_n;
    logic [7:0]    sh, sh_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          phase, phase_n;
    logic          sh_full, sh_full_n;
    logic [1:0]    seg, seg_n;
    logic [PW-1:0] poll_cnt, poll_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          err_q, err_n;

    logic bit_active, byte_end, gap_last, last_read, range_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            bytes_left <= '0;
            sh         <= '0;
            bit_idx    <= '0;
            phase      <= 1'b0;
            sh_full    <= 1'b0;
            seg        <= '0;
            poll_cnt   <= '0;
            gap_cnt    <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            bytes_left <= bytes_left_n;
            sh         <= sh_n;
            bit_idx    <= bit_idx_n;
            phase      <= phase_n;
            sh_full    <= sh_full_n;
            seg        <= seg_n;
            poll_cnt   <= poll_cnt_n;
            gap_cnt    <= gap_cnt_n;
            err_q      <= err_n;
        end
    end

    // A bit is on the wire in every command state, and in PP_DATA only once a payload byte is loaded.
    always_comb begin
        bit_active = (state == WREN) || (state == PP_CMD) || (state == PP_ADDR) || (state == RDSR) ||
                     ((state == PP_DATA) && sh_full);
        byte_end   = bit_active && phase && (bit_idx == 3'd7);
        gap_last   = (gap_cnt == GW'(CS_GAP_CYCLES - 1));
        last_read  = (({1'b0, poll_cnt} + 1'b1) == (PW + 1)'(POLL_MAX));
        range_bad  = (bytes_left == 9'd0) || (bytes_left > 9'd256) ||
                     (({2'b00, addr_q[7:0]} + {1'b0, bytes_left}) > 10'd256);
    end

    always_comb begin
        state_n      = state;
        addr_n       = addr_q;
        bytes_left_n = bytes_left;
        sh_n         = sh;
        bit_idx_n    = bit_idx;
        phase_n      = phase;
        sh_full_n    = sh_full;
        seg_n        = seg;
        poll_cnt_n   = poll_cnt;
        gap_cnt_n    = gap_cnt;
        err_n        = err_q;

        // Phase A drives MOSI from sh[7]; the end of phase B shifts to the next bit.
        if (bit_active) begin
            phase_n = ~phase;
            if (phase) begin
                sh_n      = {sh[6:0], 1'b0};
                bit_idx_n = bit_idx + 3'd1;
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    addr_n       = address;
                    bytes_left_n = byte_count;
                    err_n        = 1'b0;
                    poll_cnt_n   = '0;
                    state_n      = CHECK;
                end
            end
            CHECK: begin
                if (range_bad) begin
                    err_n   = 1'b1;
                    state_n = FINISH;
                end else begin
                    sh_n      = 8'h06;
                    bit_idx_n = 3'd0;
                    phase_n   = 1'b0;
                    state_n   = WREN;
                end
            end
            WREN: begin
                if (byte_end) begin
                    gap_cnt_n = '0;
                    state_n   = GAP1;
                end
            end
            GAP1: begin
                if (gap_last) begin
                    gap_cnt_n = '0;
                    sh_n      = 8'h02;
                    state_n   = PP_CMD;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            PP_CMD: begin
                if (byte_end) begin
                    sh_n    = addr_q[23:16];
                    seg_n   = 2'd0;
                    state_n = PP_ADDR;
                end
            end
            PP_ADDR: begin
                if (byte_end) begin
                    if (seg == 2'd0) begin
                        sh_n  = addr_q[15:8];
                        seg_n = 2'd1;
                    end else if (seg == 2'd1) begin
                        sh_n  = addr_q[7:0];
                        seg_n = 2'd2;
                    end else begin
                        sh_full_n = 1'b0;
                        state_n   = PP_DATA;
                    end
                end
            end
            // data_in is taken on any clock where data_valid && data_ready; data_ready never depends
            // on data_valid, and while data_valid stays low the bus simply stalls with cs held low.
            PP_DATA: begin
                if (!sh_full) begin
                    if (data_valid && data_ready) begin
                        sh_n         = data_in;
                        sh_full_n    = 1'b1;
                        bytes_left_n = bytes_left - 9'd1;
                        bit_idx_n    = 3'd0;
                        phase_n      = 1'b0;
                    end
                end else if (byte_end) begin
                    sh_full_n = 1'b0;
                    if (bytes_left == 9'd0) begin
                        gap_cnt_n = '0;
                        state_n   = GAP2;
                    end
                end
            end
            GAP2, POLL_GAP: begin
                if (gap_last) begin
                    gap_cnt_n = '0;
                    sh_n      = 8'h05;
                    seg_n     = 2'd0;
                    state_n   = RDSR;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            // The final sampled bit of the status byte is WIP, so it is taken straight from MISO.
            RDSR: begin
                if (byte_end) begin
                    if (seg == 2'd0) begin
                        seg_n = 2'd1;
                        sh_n  = 8'h00;
                    end else begin
                        poll_cnt_n = poll_cnt + 1'b1;
                        if (!flash_miso) begin
                            err_n   = 1'b0;
                            state_n = FINISH;
                        end else if (last_read) begin
                            err_n   = 1'b1;
                            state_n = FINISH;
                        end else begin
                            gap_cnt_n = '0;
                            state_n   = POLL_GAP;
                        end
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        flash_cs   = !((state == WREN) || (state == PP_CMD) || (state == PP_ADDR) ||
                       (state == PP_DATA) || (state == RDSR));
        flash_clk  = bit_active && phase;
        flash_mosi = bit_active && sh[7];
        data_ready = (state == PP_DATA) && !sh_full && (bytes_left != 9'd0);
        busy       = (state != IDLE);
        done       = (state == FINISH);
        error      = (state == FINISH) && err_q;
        dbg_state  = state;
    end

endmodule

// File: tb/tb_flash_page_writer.sv
// Randomized bench for flash_page_writer: a flash model decodes MOSI frames and a
// scoreboard compares them, and each completion, against expectations from a reference model.
module tb_flash_page_writer;

  localparam int POLL_MAX_TB = 3;
  localparam int GAP_TB      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] address = '0;
  logic [8:0]  byte_count = '0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready, busy, done, error;
  logic        flash_clk, flash_mosi, flash_cs;
  logic        flash_miso = 1'b0;
  logic [3:0]  dbg_state;

  flash_page_writer #(.CS_GAP_CYCLES(GAP_TB), .POLL_MAX(POLL_MAX_TB)) dut (
    .clk(clk), .rst(rst), .start(start), .address(address), .byte_count(byte_count),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .done(done), .error(error), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso), .flash_cs(flash_cs), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // scoreboard state
  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  logic       exp_res_q[$];
  logic [7:0] feed_q[$];
  logic [7:0] fixed_q[$];

  int n_total = 0;
  int n_pass  = 0;

  int  done_cnt = 0;
  int  cs_falls = 0;
  int  op_bytes = 0;
  int  rd_idx = 0;
  int  cur_wip_ones = 0;
  bit  stall_mode = 1'b0;
  bit  ignore_frame = 1'b0;
  int  stall_cnt = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // payload driver: presents the next queued byte, optionally gated by a 20-on/20-off pattern
  initial begin
    bit xfer;
    forever begin
      @(negedge clk);
      xfer = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (xfer && feed_q.size() > 0) void'(feed_q.pop_front());
      stall_cnt++;
      data_valid = (feed_q.size() > 0) && (!stall_mode || ((stall_cnt / 20) % 2 == 0));
      data_in    = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    end
  end

  // flash model + monitor
  initial begin
    logic       prev_cs = 1'b1;
    logic       prev_fclk = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] bitbuf = '0;
    logic [7:0] first = '0;
    logic [7:0] e;
    int         nbits = 0;
    int         flen = 0;
    int         gap_run = 0;
    int         el;
    bit         had_frame = 1'b0;
    logic       er;
    forever begin
      @(negedge clk);
      if (!flash_cs && prev_cs) begin
        if (had_frame) check("cs_gap", gap_run >= GAP_TB, gap_run, GAP_TB);
        gap_run = 0; flen = 0; nbits = 0; cs_falls++;
        flash_miso = (rd_idx < cur_wip_ones);
      end
      if (!flash_cs && flash_clk && !prev_fclk) begin
        bitbuf = {bitbuf[6:0], flash_mosi};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (flen == 0) first = bitbuf;
          flen++; op_bytes++;
          if (exp_q.size() == 0) check("mosi_byte_unexpected", 1'b0, bitbuf, 0);
          else begin
            e = exp_q.pop_front();
            check("mosi_byte", bitbuf == e, bitbuf, e);
          end
        end
      end
      if (flash_cs && !prev_cs) begin
        if (ignore_frame) begin
          ignore_frame = 1'b0; had_frame = 1'b0;
        end else begin
          if (exp_len_q.size() == 0) check("frame_unexpected", 1'b0, flen, 0);
          else begin
            el = exp_len_q.pop_front();
            check("frame_len", flen == el && nbits == 0, flen, el);
          end
          had_frame = 1'b1;
          if (first == 8'h05 && flen == 2) rd_idx++;
        end
        nbits = 0;
      end
      if (flash_cs) begin
        gap_run++;
        check("mosi_idle", flash_mosi == 1'b0, flash_mosi, 0);
      end
      if (data_ready && !data_valid)
        check("stall_frozen", !flash_clk && !flash_cs, {flash_clk, flash_cs}, 0);
      if (done) begin
        check("done_single", !prev_done, prev_done, 0);
        check("busy_at_done", busy == 1'b1, busy, 1);
        if (exp_res_q.size() == 0) check("done_unexpected", 1'b0, error, 0);
        else begin
          er = exp_res_q.pop_front();
          check("error", error == er, error, er);
        end
        done_cnt++;
        had_frame = 1'b0;
      end
      prev_cs = flash_cs; prev_fclk = flash_clk; prev_done = done;
    end
  end

  task automatic flush_all();
    exp_q.delete(); exp_len_q.delete(); exp_res_q.delete(); feed_q.delete();
    data_valid = 1'b0;
  endtask

  // Reference model: the frames and result a correct page program must produce.
  task automatic run_op(input logic [23:0] a, input int n, input int wip_ones,
                        input bit stall, input bit poke, input bit abort);
    bit         legal;
    int         reads, d0, c0, cyc, ab_wait;
    bit         aborted;
    logic [7:0] b;
    legal = (n >= 1) && (n <= 256) && (int'(a[7:0]) + n <= 256);
    if (legal) begin
      exp_len_q.push_back(1); exp_q.push_back(8'h06);
      exp_len_q.push_back(4 + n);
      exp_q.push_back(8'h02); exp_q.push_back(a[23:16]); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
      for (int i = 0; i < n; i++) begin
        b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
        exp_q.push_back(b); feed_q.push_back(b);
      end
      reads = (wip_ones + 1 < POLL_MAX_TB) ? wip_ones + 1 : POLL_MAX_TB;
      for (int i = 0; i < reads; i++) begin
        exp_len_q.push_back(2); exp_q.push_back(8'h05); exp_q.push_back(8'h00);
      end
      exp_res_q.push_back(wip_ones >= POLL_MAX_TB);
    end else begin
      exp_res_q.push_back(1'b1);
    end
    cur_wip_ones = wip_ones; rd_idx = 0; stall_mode = stall; stall_cnt = 0; op_bytes = 0;
    d0 = done_cnt; c0 = cs_falls;
    @(negedge clk); #1;
    start = 1'b1; address = a; byte_count = 9'(n);
    cyc = 0; ab_wait = 0; aborted = 1'b0;
    while (done_cnt == d0 && cyc < 30000 && !aborted) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_after_start", busy == 1'b1, busy, 1);
      end
      if (poke && cyc == 100) begin
        start = 1'b1; address = 24'($urandom); byte_count = 9'd3;
      end
      if (poke && cyc == 101) start = 1'b0;
      if (abort && op_bytes >= 2) begin
        if (ab_wait < 3) ab_wait++;
        else begin
          rst = 1'b1; ignore_frame = 1'b1;
          @(posedge clk); #1;
          check("abort_cs", flash_cs == 1'b1, flash_cs, 1);
          check("abort_clk", flash_clk == 1'b0, flash_clk, 0);
          check("abort_busy", busy == 1'b0, busy, 0);
          rst = 1'b0;
          flush_all();
          aborted = 1'b1;
        end
      end
    end
    if (aborted) begin
      repeat (40) @(negedge clk);
      check("abort_no_done", done_cnt == d0, done_cnt - d0, 0);
    end else begin
      check("done_timeout", done_cnt != d0, cyc, 30000);
      if (!legal) begin
        check("reject_latency", cyc <= 3, cyc, 3);
        check("reject_no_cs", cs_falls == c0, cs_falls - c0, 0);
      end else begin
        check("frames_all_seen", exp_q.size() == 0 && exp_len_q.size() == 0, exp_q.size(), 0);
        check("payload_consumed", feed_q.size() == 0, feed_q.size(), 0);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, w;
    logic [23:0] a;
    repeat (4) @(negedge clk);
    #1;
    check("rst_cs", flash_cs == 1'b1, flash_cs, 1);
    check("rst_clk_mosi", {flash_clk, flash_mosi} == 2'b00, {flash_clk, flash_mosi}, 0);
    check("rst_ready", data_ready == 1'b0, data_ready, 0);
    check("rst_busy_done_err", {busy, done, error} == 3'b000, {busy, done, error}, 0);
    start = 1'b1;
    @(negedge clk); #1;
    check("start_during_rst_ignored", busy == 1'b0, busy, 0);
    start = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);

    fixed_q = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    run_op(24'h000100, 4, 0, 1'b0, 1'b0, 1'b0);
    run_op(24'h0000F0, 17, 0, 1'b0, 1'b0, 1'b0);
    run_op(24'h001200, 0, 0, 1'b0, 1'b0, 1'b0);
    run_op(24'h001200, 257, 0, 1'b0, 1'b0, 1'b0);
    run_op(24'h000001, 256, 0, 1'b0, 1'b0, 1'b0);
    run_op(24'hABCDFF, 1, 0, 1'b0, 1'b0, 1'b0);
    run_op(24'h123400, 256, 0, 1'b1, 1'b1, 1'b0);
    run_op(24'h000010, 3, 1000, 1'b0, 1'b0, 1'b0);
    run_op(24'h000020, 5, 2, 1'b0, 1'b0, 1'b0);
    run_op(24'h000100, 8, 0, 1'b0, 1'b0, 1'b1);
    run_op(24'h000200, 6, 1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      a = 24'($urandom);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(1, 48);
      w = $urandom_range(0, 4);
      run_op(a, n, w, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/flash_page_writer.md
FLASH_PAGE_WRITER -- requirements
Module: flash_page_writer

Interface
REQ-001 Parameter CS_GAP_CYCLES, default 4: minimum clk cycles flash_cs held high between commands.
REQ-002 Parameter POLL_MAX, default 65535: maximum status-register reads before timeout.
REQ-003 Port clk, input, 1: sole clock; all logic on posedge clk.
REQ-004 Port rst, input, 1: synchronous reset, active-high.
REQ-005 Port start, input, 1: request one page-program operation; sampled only in IDLE.
REQ-006 Port address, input, 24: flash byte address; latched on accepted start.
REQ-007 Port byte_count, input, 9: bytes to program, legal 1..256; latched on accepted start.
REQ-008 Port data_in, input, 8: next payload byte.
REQ-009 Port data_valid, input, 1: data_in valid.
REQ-010 Port data_ready, output, 1: block accepts data_in this cycle.
REQ-011 Port busy, output, 1: high from the cycle after an accepted start until the cycle done pulses, inclusive.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port error, output, 1: valid only while done=1; 1 = rejected or timed out.
REQ-014 Port flash_clk, output, 1: SPI SCK, mode 0.
REQ-015 Port flash_mosi, output, 1: SPI data to flash, MSB first.
REQ-016 Port flash_miso, input, 1: SPI data from flash.
REQ-017 Port flash_cs, output, 1: SPI chip select, active-low.

Function
REQ-018 SCK = clk/2: each bit takes 2 cycles, phase A with flash_clk=0 and flash_mosi updated, then phase B with flash_clk=1 and flash_miso sampled.
REQ-019 States: IDLE, CHECK, WREN, GAP1, PP_CMD, PP_ADDR, PP_DATA, GAP2, RDSR, POLL_GAP, FINISH.
REQ-020 IDLE + start=1 -> latch address and byte_count, go to CHECK; start while busy is ignored.
REQ-021 CHECK: byte_count==0, byte_count>256, or address[7:0]+byte_count>256 -> FINISH with error=1 and no flash activity; otherwise go to WREN.
REQ-022 WREN: cs low, send 0x06 (8 bits), raise cs, go to GAP1.
REQ-023 GAP1/GAP2/POLL_GAP: hold cs high for CS_GAP_CYCLES cycles, flash_clk=0.
REQ-024 PP_CMD: cs low, send 0x02, then PP_ADDR sends address[23:0] MSB first, cs stays low.
REQ-025 PP_DATA: data_ready=1 only when the shift register is empty and bytes remain; a transfer occurs on data_valid&&data_ready.
REQ-026 Each transferred byte is shifted out MSB first; data_ready is low during its 16 cycles.
REQ-027 data_valid low in PP_DATA: flash_clk held 0, cs held low, no bit advance (stall, unbounded).
REQ-028 After the last byte's final phase B -> raise cs, go to GAP2.
REQ-029 RDSR: cs low, send 0x05, clock 8 more bits capturing flash_miso into status, raise cs; bit0 (WIP)=0 -> FINISH error=0; else POLL_GAP then RDSR again.
REQ-030 Poll counter increments per status read; the POLL_MAX-th read with WIP=1 -> FINISH error=1.
REQ-031 FINISH: done=1 for exactly one cycle with error, busy=1 in that cycle, then IDLE.
REQ-032 flash_mosi=0 whenever cs is high or no bit is being sent.
REQ-033 Byte counter width 9 bits; 256 bytes shall complete without wrap.

Reset
REQ-034 rst=1 -> state IDLE, flash_cs=1, flash_clk=0, flash_mosi=0, data_ready=0, busy=0, done=0, error=0, counters 0.
REQ-035 rst asserted mid-operation aborts on the next edge with the REQ-034 values and no done pulse; start in the same cycle as rst is ignored.

Verification
REQ-036 start, address=0x000100, byte_count=4, bytes A5 5A 00 FF always valid, flash model WIP=0 -> MOSI frames 06 | 02 00 01 00 A5 5A 00 FF | 05; done=1, error=0.
REQ-037 address=0x0000F0, byte_count=17 -> done=1, error=1 within 3 cycles; flash_cs never low.
REQ-038 byte_count=256, data_valid toggled 1/0 every 20 cycles -> 256 bytes in order, flash_clk frozen low during stalls, cs continuously low across PP.
REQ-039 POLL_MAX=3, model WIP stuck 1 -> exactly 3 RDSR frames, each separated by >=4 cycles of cs high, then done=1, error=1.
REQ-040 Model WIP=1 for 2 reads then 0 -> 3 RDSR frames, done=1, error=0.
REQ-041 rst pulsed during PP_ADDR -> next cycle cs=1, clk=0, busy=0; no done; a following start runs normally.
